// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter
//   Round-robin AHB arbiter that shares the single AHB-to-APB bridge slave
//   port among NUM_MASTERS masters. Bursts are never split; bus tenure is
//   capped at MAX_BEATS accepted transfers while other masters are waiting.
//   All outputs are registered.
//
//   Optional feature macro: AHB_LOCK_EN (locked transfers via hlock/hmastlock).
//   With the macro undefined, hlock is ignored and hmastlock is constant 0.
//
// Ports
//   hclk          in   bus clock, rising edge
//   hreset        in   asynchronous active-high reset
//   hbusreq       in   per-master bus request
//   hlock         in   per-master locked-transfer request (AHB_LOCK_EN only)
//   htrans        in   htrans of the current owner (IDLE/BUSY/NONSEQ/SEQ)
//   hready        in   bridge hreadyout, 1 = transfer completes this cycle
//   hgrant        out  one-hot grant
//   hmaster       out  address-phase owner index
//   hmaster_data  out  data-phase owner index (hwdata mux select)
//   hmastlock     out  current address phase is locked
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_BEATS      = 8,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic [MW-1:0]          hmaster_data,
  output logic                   hmastlock
);

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

`ifdef AHB_LOCK_EN
  typedef enum logic [1:0] {ST_PARK, ST_OWNED, ST_LOCKED} state_e;
`else
  typedef enum logic [0:0] {ST_PARK, ST_OWNED} state_e;
`endif

  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [7:0]    MAX_CNT = 8'(MAX_BEATS);

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] hgrant_q;
  logic [MW-1:0]          hmaster_q;
  logic [MW-1:0]          hmaster_data_q;
  logic                   hmastlock_q;
  logic [7:0]             beat_cnt_q;
  logic [MW-1:0]          last_owner_q;

  logic                   accepted;
  logic                   arb_point;
  logic                   rearb;
  logic                   any_req;
  logic                   any_other;
  logic                   own_req;
  logic                   keep;
  logic                   rr_found;
  logic                   arb_lock;
  logic [7:0]             cnt_base;
  logic [7:0]             cnt_inc;
  logic [MW-1:0]          rr_idx;
  logic [MW-1:0]          arb_owner;
  int unsigned            cand;

`ifndef AHB_LOCK_EN
  logic unused_hlock;
  assign unused_hlock = ^hlock;
`endif

  always_comb begin
    accepted  = hready && htrans[1];
    arb_point = hready && (htrans == HT_IDLE || htrans == HT_NONSEQ);

    // Beats seen while parked are not part of any tenure.
    cnt_base = (state_q == ST_PARK) ? '0 : beat_cnt_q;
    cnt_inc  = (accepted && cnt_base != MAX_CNT) ? cnt_base + 8'd1 : cnt_base;

    any_req   = |hbusreq;
    own_req   = hbusreq[hmaster_q];
    any_other = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (hbusreq[i] && MW'(i) != hmaster_q) any_other = 1'b1;
    end

    // Search starts one past the last owner and wraps back to it last.
    rr_found = 1'b0;
    rr_idx   = DEF_IDX;
    cand     = 0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = (32'(last_owner_q) + i) % NUM_MASTERS;
      if (!rr_found && hbusreq[cand]) begin
        rr_found = 1'b1;
        rr_idx   = MW'(cand);
      end
    end

    // The beat accepted in this cycle counts toward the cap, so a tenure
    // under contention ends after exactly MAX_BEATS accepted transfers.
    keep = own_req && ((cnt_inc < MAX_CNT) || !any_other);
    if (keep)         arb_owner = hmaster_q;
    else if (any_req) arb_owner = rr_idx;
    else              arb_owner = DEF_IDX;

`ifdef AHB_LOCK_EN
    rearb    = arb_point && (state_q != ST_LOCKED ||
                             (!hlock[hmaster_q] && htrans == HT_IDLE));
    arb_lock = any_req && hlock[arb_owner];
`else
    rearb    = arb_point;
    arb_lock = 1'b0;
`endif
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q        <= ST_PARK;
      hgrant_q       <= onehot(DEF_IDX);
      hmaster_q      <= DEF_IDX;
      hmaster_data_q <= DEF_IDX;
      hmastlock_q    <= 1'b0;
      beat_cnt_q     <= '0;
      last_owner_q   <= DEF_IDX;
    end else begin
      if (hready) hmaster_data_q <= hmaster_q;
      beat_cnt_q <= cnt_inc;
      if (rearb) begin
        hgrant_q     <= onehot(arb_owner);
        hmaster_q    <= arb_owner;
        last_owner_q <= arb_owner;
        hmastlock_q  <= arb_lock;
        if (arb_owner != hmaster_q || !any_req) beat_cnt_q <= '0;
        if (!any_req) begin
          state_q <= ST_PARK;
`ifdef AHB_LOCK_EN
        end else if (arb_lock) begin
          state_q <= ST_LOCKED;
`endif
        end else begin
          state_q <= ST_OWNED;
        end
      end
    end
  end

  assign hgrant       = hgrant_q;
  assign hmaster      = hmaster_q;
  assign hmaster_data = hmaster_data_q;
  assign hmastlock    = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter
//   Directed bench for ahb_bus_arbiter with its default parameters
//   (4 masters, default master 0, MAX_BEATS 8). Inputs change 1 ns after
//   the rising edge; outputs are checked at the same point.
module tb_ahb_bus_arbiter;

  logic       hclk;
  logic       hreset;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic [1:0] hmaster_data;
  logic       hmastlock;

  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          exp_o;

  ahb_bus_arbiter #(
    .NUM_MASTERS   (4),
    .DEFAULT_MASTER(0),
    .MAX_BEATS     (8)
  ) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .hbusreq     (hbusreq),
    .hlock       (hlock),
    .htrans      (htrans),
    .hready      (hready),
    .hgrant      (hgrant),
    .hmaster     (hmaster),
    .hmaster_data(hmaster_data),
    .hmastlock   (hmastlock)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " hgrant"},       32'(hgrant),       32'h1);
    chk({tag, " hmaster"},      32'(hmaster),      32'h0);
    chk({tag, " hmaster_data"}, 32'(hmaster_data), 32'h0);
    chk({tag, " hmastlock"},    32'(hmastlock),    32'h0);
  endtask

  initial begin
    hreset  = 1'b1;
    hbusreq = 4'b0000;
    hlock   = 4'b0000;
    htrans  = IDLE;
    hready  = 1'b1;
    repeat (2) @(posedge hclk);
    #1;
    chk_reset("reset");

    // Single requester M2 from park
    hreset  = 1'b0;
    hbusreq = 4'b0100;
    tick();
    chk("m2 hgrant",       32'(hgrant),       32'b0100);
    chk("m2 hmaster",      32'(hmaster),      32'd2);
    chk("m2 hmaster_data", 32'(hmaster_data), 32'd0);
    tick();
    chk("m2 hmaster_data next", 32'(hmaster_data), 32'd2);

    // M1 takes the bus, runs a 4-beat INCR; M3 requests at beat 2
    hbusreq = 4'b0010;
    tick();
    chk("m1 hgrant",  32'(hgrant),  32'b0010);
    chk("m1 hmaster", 32'(hmaster), 32'd1);
    htrans = NONSEQ;
    tick();
    chk("burst b1", 32'(hmaster), 32'd1);
    htrans  = SEQ;
    hbusreq = 4'b1000;
    tick();
    chk("burst b2", 32'(hmaster), 32'd1);
    hready = 1'b0;
    tick();
    chk("burst stall", 32'(hmaster), 32'd1);
    hready = 1'b1;
    tick();
    chk("burst b3", 32'(hmaster), 32'd1);
    tick();
    chk("burst b4", 32'(hmaster), 32'd1);
    htrans = IDLE;
    hready = 1'b0;
    tick();
    chk("ap stalled", 32'(hmaster), 32'd1);
    hready = 1'b1;
    tick();
    chk("handover hmaster",      32'(hmaster),      32'd3);
    chk("handover hgrant",       32'(hgrant),       32'b1000);
    chk("handover hmaster_data", 32'(hmaster_data), 32'd1);

    // All request, single NONSEQs: 8-transfer tenures rotating 3,0,1,2,3
    hbusreq = 4'b1111;
    htrans  = NONSEQ;
    for (int t = 0; t < 5; t++) begin
      exp_o = (3 + t) % 4;
      for (int b = 1; b <= 8; b++) begin
        tick();
        chk($sformatf("rotate t%0d b%0d", t, b), 32'(hmaster),
            32'((b < 8) ? exp_o : (exp_o + 1) % 4));
      end
    end

    // M0 alone keeps the bus well past MAX_BEATS
    hbusreq = 4'b0001;
    for (int b = 1; b <= 20; b++) begin
      tick();
      chk($sformatf("m0 alone b%0d", b), 32'(hmaster), 32'd0);
    end
    chk("m0 alone hgrant", 32'(hgrant), 32'b0001);

    // Park back on the default master when nobody requests
    hbusreq = 4'b0100;
    htrans  = IDLE;
    tick();
    chk("pre-park hmaster", 32'(hmaster), 32'd2);
    hbusreq = 4'b0000;
    tick();
    chk("park hmaster", 32'(hmaster), 32'd0);
    chk("park hgrant",  32'(hgrant),  32'b0001);

`ifdef AHB_LOCK_EN
    // Locked M2 holds the bus past MAX_BEATS while M0 waits
    hbusreq = 4'b0100;
    hlock   = 4'b0100;
    tick();
    chk("lock hmaster",   32'(hmaster),   32'd2);
    chk("lock hmastlock", 32'(hmastlock), 32'd1);
    hbusreq = 4'b0101;
    htrans  = NONSEQ;
    for (int b = 1; b <= 12; b++) begin
      tick();
      chk($sformatf("locked b%0d", b), 32'(hmaster), 32'd2);
    end
    chk("locked hmastlock", 32'(hmastlock), 32'd1);
    hlock = 4'b0000;
    tick();
    chk("unlock nonseq hmaster", 32'(hmaster), 32'd2);
    htrans = IDLE;
    tick();
    chk("unlock idle hmaster",   32'(hmaster),   32'd0);
    chk("unlock idle hmastlock", 32'(hmastlock), 32'd0);
`else
    // hlock has no effect: M2 is capped at 8 transfers, hmastlock stays 0
    hbusreq = 4'b0100;
    hlock   = 4'b1111;
    tick();
    chk("nolock hmaster",   32'(hmaster),   32'd2);
    chk("nolock hmastlock", 32'(hmastlock), 32'd0);
    hbusreq = 4'b0101;
    htrans  = NONSEQ;
    for (int b = 1; b <= 8; b++) begin
      tick();
      chk($sformatf("nolock b%0d", b), 32'(hmaster), 32'((b < 8) ? 2 : 0));
    end
    chk("nolock hmastlock end", 32'(hmastlock), 32'd0);
    hlock  = 4'b0000;
    htrans = IDLE;
`endif

    // Asynchronous reset in the middle of an M2 burst
    hbusreq = 4'b0100;
    tick();
    chk("pre-reset hmaster", 32'(hmaster), 32'd2);
    htrans = NONSEQ;
    tick();
    chk("pre-reset hmaster_data", 32'(hmaster_data), 32'd2);
    htrans = SEQ;
    tick();
    #2;
    hreset = 1'b1;
    #1;
    chk_reset("midburst reset");
    #10;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
